// File: rtl/apb_csb_pkg.sv
// Shared types and constants for the APB-to-CSB bridge.
// The optional timeout path is selected with APB_CSB_TIMEOUT_EN.
package apb_csb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned APB_AW          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CSB_ADDR_LSB    = 2;
  localparam int unsigned CSB_AW          = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/apb_csb_timer.sv
// Saturating cycle counter: cleared on request entry, flags expiry after LIMIT counted cycles.
// Instantiated by the bridge only when APB_CSB_TIMEOUT_EN is defined.
module apb_csb_timer
  import apb_csb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is seen in the LIMIT-th counted cycle so the FSM leaves on that edge.
  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_csb_responder.sv
// APB completer turning each word-aligned access into one NVDLA CSB transaction.
// Define APB_CSB_TIMEOUT_EN to add the request/response timeout and stale-response drain.
module apb_csb_responder
  import apb_csb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [APB_AW-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              csb_valid_o,
  input  logic              csb_ready_i,
  output logic [CSB_AW-1:0] csb_addr_o,
  output logic [DATA_W-1:0] csb_wdat_o,
  output logic              csb_write_o,
  output logic              csb_nposted_o,
  input  logic              csb_rvalid_i,
  input  logic [DATA_W-1:0] csb_rdata_i
);

  state_e            state_q, state_d;
  logic              accept_c, err_c, capture_c;
  logic              timeout_c, drain_q;

  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              csb_valid_q, csb_valid_d;
  logic [CSB_AW-1:0] csb_addr_q, csb_addr_d;
  logic [DATA_W-1:0] csb_wdat_q, csb_wdat_d;
  logic              csb_write_q, csb_write_d;

`ifdef APB_CSB_TIMEOUT_EN
  logic expired_c, drain_d;

  apb_csb_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (accept_c),
    .en_i      ((state_q == REQ) || (state_q == WAIT_RD)),
    .expired_o (expired_c)
  );

  assign timeout_c = expired_c;

  // A read abandoned in WAIT_RD still owes one response; swallow it when it arrives.
  always_comb begin
    drain_d = drain_q;
    if (csb_rvalid_i) drain_d = 1'b0;
    if ((state_q == WAIT_RD) && err_c) drain_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drain_q <= 1'b0;
    else       drain_q <= drain_d;
  end
`else
  assign timeout_c = 1'b0;
  assign drain_q   = 1'b0;
`endif

  logic unused_c;
  assign unused_c = ^{paddr_i[APB_AW-1:CSB_ADDR_LSB+CSB_AW], 32'(TIMEOUT)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    err_c     = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          if (paddr_i[CSB_ADDR_LSB-1:0] == '0) begin
            state_d  = REQ;
            accept_c = 1'b1;
          end else begin
            state_d = DONE;
            err_c   = 1'b1;
          end
        end
      end
      REQ: begin
        if (csb_ready_i) begin
          state_d = csb_write_q ? DONE : WAIT_RD;
        end else if (timeout_c) begin
          state_d = DONE;
          err_c   = 1'b1;
        end
      end
      WAIT_RD: begin
        if (csb_rvalid_i && !drain_q) begin
          state_d   = DONE;
          capture_c = 1'b1;
        end else if (timeout_c) begin
          state_d = DONE;
          err_c   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so pready/valid line up with the FSM.
  always_comb begin
    pready_d    = (state_d == DONE);
    pslverr_d   = err_c;
    csb_valid_d = (state_d == REQ);
    prdata_d    = prdata_q;
    csb_addr_d  = csb_addr_q;
    csb_wdat_d  = csb_wdat_q;
    csb_write_d = csb_write_q;
    if (capture_c) begin
      prdata_d = csb_rdata_i;
    end else if (err_c) begin
      prdata_d = '0;
    end
    if (accept_c) begin
      csb_addr_d  = paddr_i[CSB_ADDR_LSB +: CSB_AW];
      csb_wdat_d  = pwdata_i;
      csb_write_d = pwrite_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      csb_valid_q <= 1'b0;
      csb_addr_q  <= '0;
      csb_wdat_q  <= '0;
      csb_write_q <= 1'b0;
    end else begin
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      csb_valid_q <= csb_valid_d;
      csb_addr_q  <= csb_addr_d;
      csb_wdat_q  <= csb_wdat_d;
      csb_write_q <= csb_write_d;
    end
  end

  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;
  assign csb_valid_o   = csb_valid_q;
  assign csb_addr_o    = csb_addr_q;
  assign csb_wdat_o    = csb_wdat_q;
  assign csb_write_o   = csb_write_q;
  assign csb_nposted_o = 1'b0;

endmodule

// File: tb/tb_apb_csb_responder.sv
// Directed and random bench for apb_csb_responder with a behavioural CSB device and scoreboards.
// The timeout scenario is exercised when APB_CSB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_csb_responder;

  localparam int TB_TIMEOUT = 16;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdat;
  } csb_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } apb_exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o;
  logic        pready_o, pslverr_o;
  logic        csb_valid_o, csb_ready_i;
  logic [15:0] csb_addr_o;
  logic [31:0] csb_wdat_o;
  logic        csb_write_o, csb_nposted_o;
  logic        csb_rvalid_i;
  logic [31:0] csb_rdata_i;

  always #5 clk_i = ~clk_i;

  apb_csb_responder #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .psel_i        (psel_i),
    .penable_i     (penable_i),
    .pwrite_i      (pwrite_i),
    .paddr_i       (paddr_i),
    .pwdata_i      (pwdata_i),
    .prdata_o      (prdata_o),
    .pready_o      (pready_o),
    .pslverr_o     (pslverr_o),
    .csb_valid_o   (csb_valid_o),
    .csb_ready_i   (csb_ready_i),
    .csb_addr_o    (csb_addr_o),
    .csb_wdat_o    (csb_wdat_o),
    .csb_write_o   (csb_write_o),
    .csb_nposted_o (csb_nposted_o),
    .csb_rvalid_i  (csb_rvalid_i),
    .csb_rdata_i   (csb_rdata_i)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          n_xfer = 0;
  int          n_pready = 0;
  int          ready_dly = 0;
  int          rv_dly = 1;
  int          cyc = 0;
  logic [31:0] exp_prdata = '0;

  csb_t        csb_q[$];
  apb_exp_t    apb_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] dev_mem[logic [15:0]];
  logic [31:0] ref_mem[logic [15:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] dev_rd(input logic [15:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return {16'hC5B0, a};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {16'hC5B0, a};
  endfunction

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  always @(negedge clk_i) if (pready_o === 1'b1) n_pready++;

  // CSB device: programmable ready stall, in-order read responses after rv_dly cycles.
  initial begin : csb_device
    csb_t got, prev, want;
    rsp_t r;
    int   wait_cnt;
    int   last_due;
    wait_cnt = 0;
    last_due = 0;
    prev = '0;
    csb_ready_i  = 1'b0;
    csb_rvalid_i = 1'b0;
    csb_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      csb_rvalid_i = 1'b0;
      csb_rdata_i  = $urandom;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front();
        csb_rvalid_i = 1'b1;
        csb_rdata_i  = r.data;
      end
      got = {csb_write_o, csb_addr_o, csb_wdat_o};
      if (csb_valid_o === 1'b1) begin
        check("csb_nposted", 32'(csb_nposted_o), 32'd0);
        if (wait_cnt > 0) begin
          check("csb_stable_addr", 32'(got.addr), 32'(prev.addr));
          check("csb_stable_wdat", got.wdat, prev.wdat);
          check("csb_stable_write", 32'(got.wr), 32'(prev.wr));
        end
        if (wait_cnt >= ready_dly) begin
          csb_ready_i = 1'b1;
          wait_cnt = 0;
          check("csb_req_expected", 32'(csb_q.size() > 0), 32'd1);
          if (csb_q.size() > 0) begin
            want = csb_q.pop_front();
            check("csb_write", 32'(got.wr), 32'(want.wr));
            check("csb_addr", 32'(got.addr), 32'(want.addr));
            check("csb_wdat", got.wdat, want.wdat);
          end
          if (got.wr) begin
            dev_mem[got.addr] = got.wdat;
          end else begin
            r.due = (cyc + rv_dly > last_due + 1) ? cyc + rv_dly : last_due + 1;
            r.data = dev_rd(got.addr);
            last_due = r.due;
            rsp_q.push_back(r);
          end
        end else begin
          csb_ready_i = 1'b0;
          wait_cnt++;
        end
        prev = got;
      end else begin
        csb_ready_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // mode 0: normal with latency check, 1: expect timeout error, 2: normal without latency check
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int mode);
    apb_exp_t e;
    csb_t     c;
    int       lat;
    int       exp_lat;
    logic [15:0] wa;
    wa = addr[17:2];
    exp_lat = 1;
    if (addr[1:0] != 2'b00) begin
      exp_prdata = '0;
      e = {1'b1, 32'h0};
    end else begin
      c = {wr, wa, wdata};
      csb_q.push_back(c);
      if (mode == 1) begin
        exp_prdata = '0;
        e = {1'b1, 32'h0};
        exp_lat = TB_TIMEOUT + 1;
      end else begin
        if (wr) ref_mem[wa] = wdata;
        else    exp_prdata = ref_rd(wa);
        e = {1'b0, exp_prdata};
        exp_lat = wr ? 2 + ready_dly : 2 + ready_dly + rv_dly;
      end
    end
    apb_q.push_back(e);
    @(negedge clk_i);
    check("pready_idle", 32'(pready_o), 32'd0);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    lat = 0;
    do begin
      @(negedge clk_i);
      penable_i = 1'b1;
      lat++;
    end while (pready_o !== 1'b1 && lat < 300);
    n_xfer++;
    e = apb_q.pop_front();
    check("pready_seen", 32'(pready_o), 32'd1);
    check("pslverr", 32'(pslverr_o), 32'(e.err));
    check("prdata", prdata_o, e.data);
    if (mode != 2) check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic apb_idle();
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    logic [31:0] a;
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_prdata", prdata_o, 32'd0);
    check("rst_pready", 32'(pready_o), 32'd0);
    check("rst_pslverr", 32'(pslverr_o), 32'd0);
    check("rst_csb_valid", 32'(csb_valid_o), 32'd0);
    check("rst_csb_addr", 32'(csb_addr_o), 32'd0);
    check("rst_csb_wdat", csb_wdat_o, 32'd0);
    check("rst_csb_write", 32'(csb_write_o), 32'd0);
    check("rst_csb_nposted", 32'(csb_nposted_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // posted write with ready held, minimum latency
    ready_dly = 0;
    apb_xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0);
    apb_idle();

    // read with stalled ready and late response
    preload(16'h0403, 32'h0000_0010);
    ready_dly = 3; rv_dly = 5;
    apb_xfer(1'b0, 32'h0000_100C, 32'h1357_9BDF, 0);
    apb_idle();

    // minimum-latency read of the earlier write
    ready_dly = 0; rv_dly = 1;
    apb_xfer(1'b0, 32'h0000_1004, 32'h0, 0);
    apb_idle();

    // unaligned access errors without touching CSB
    apb_xfer(1'b0, 32'h0000_1002, 32'h0, 0);
    apb_idle();

    // penable without psel is ignored
    @(negedge clk_i); penable_i = 1'b1; paddr_i = 32'h0000_1008;
    repeat (3) @(negedge clk_i);
    check("nopsel_valid", 32'(csb_valid_o), 32'd0);
    check("nopsel_pready", 32'(pready_o), 32'd0);
    penable_i = 1'b0;

    // reset while waiting for read data; late response must be ignored
    ready_dly = 0; rv_dly = 20;
    csb_q.push_back({1'b0, 16'h0405, 32'h0BAD_F00D});
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h0000_1014; pwdata_i = 32'h0BAD_F00D;
    @(negedge clk_i); penable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
    #1;
    check("midrst_prdata", prdata_o, 32'd0);
    check("midrst_pready", 32'(pready_o), 32'd0);
    check("midrst_pslverr", 32'(pslverr_o), 32'd0);
    check("midrst_csb_valid", 32'(csb_valid_o), 32'd0);
    check("midrst_csb_addr", 32'(csb_addr_o), 32'd0);
    check("midrst_csb_wdat", csb_wdat_o, 32'd0);
    check("midrst_csb_write", 32'(csb_write_o), 32'd0);
    exp_prdata = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    k = 0;
    while (rsp_q.size() != 0 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    check("stale_delivered", 32'(rsp_q.size()), 32'd0);
    repeat (2) @(negedge clk_i);
    check("stale_prdata", prdata_o, 32'd0);
    check("stale_no_pready", 32'(n_pready), 32'(n_xfer));
    rv_dly = 1;
    apb_xfer(1'b1, 32'h0000_1014, 32'h1234_5678, 0);
    apb_idle();
    apb_xfer(1'b0, 32'h0000_1014, 32'h0, 0);
    apb_idle();

`ifdef APB_CSB_TIMEOUT_EN
    // timeout in WAIT_RD, then the stale response is drained before the next read completes
    dev_mem[16'h0406] = 32'hAAAA_AAAA;
    ready_dly = 0; rv_dly = 30;
    apb_xfer(1'b0, 32'h0000_1018, 32'h0, 1);
    preload(16'h0407, 32'h5555_5555);
    rv_dly = 2;
    apb_xfer(1'b0, 32'h0000_101C, 32'h0, 2);
    apb_idle();
    rv_dly = 1;
`endif

    // random back-to-back traffic
    for (int i = 0; i < 100; i++) begin
      ready_dly = $urandom_range(0, 3);
      rv_dly    = $urandom_range(1, 4);
      a = {14'($urandom), 4'h2, 10'($urandom_range(0, 15)) << 2, 2'b00} ;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, 0);
    end
    apb_idle();
    repeat (10) @(negedge clk_i);

    check("pready_count", 32'(n_pready), 32'(n_xfer));
    check("csb_q_empty", 32'(csb_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
